peripheral_noc_router_packet_arbiter: RTL
=========================================

# peripheral_noc_router_packet_arbiter

Packet-atomic, round-robin arbiter that shares one router output link (or one output virtual channel) between `INPUTS` requesting input stages. Once granted, a requester keeps the link until its `last` flit is transferred, so flits of different packets never interleave. The selected flit stream passes through one registered output stage. The block sits between the router switch wiring and the output buffer: one instance per output (per VC).

## Interface

**Parameters**
- `FLIT_WIDTH`, 32, flit data width in bits.
- `INPUTS`, 4, number of requesters; ≥ 2.

**Ports** (`[INPUTS-1:0][FLIT_WIDTH-1:0]` is a packed array)
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_flit`  in  `[INPUTS-1:0][FLIT_WIDTH-1:0]`  flit from each requester.
- `in_last`  in  `INPUTS`  final flit of packet, per requester.
- `in_valid`  in  `INPUTS`  requester has a flit.
- `in_ready`  out  `INPUTS`  flit accepted this cycle; at most one bit set.
- `out_flit`  out  `FLIT_WIDTH`  registered flit to output stage.
- `out_last`  out  1  registered last marker.
- `out_valid`  out  1  `out_flit`/`out_last` valid.
- `out_ready`  in  1  downstream accepts.
- `grant`  out  `INPUTS`  one-hot current owner; all zero when idle.
- `busy`  out  1  state == LOCKED.

## Operation

- **Handshake:** a transfer occurs when valid && ready on the same rising edge. This holds on both sides.
- **State machine:** two states, IDLE and LOCKED.
  - IDLE, any `in_valid` set: pick the first set bit searching upward from `ptr`, wrapping modulo `INPUTS`. Register it into `grant`. Go to LOCKED.
  - IDLE, no `in_valid`: stay in IDLE. `grant` = 0.
  - LOCKED: `in_ready[g] = !out_valid || out_ready`. All other `in_ready` bits = 0.
  - LOCKED, transfer with `in_last[g]` = 1: next state IDLE, `grant` ← 0, `ptr` ← (g+1) mod `INPUTS`.
- **Priority pointer:** `ptr` is `$clog2(INPUTS)` bits wide and resets to 0. It advances only on packet completion, not on grant. The wrap from `INPUTS-1` returns to 0.
- **Output register:**
  - Loads `in_flit[g]`/`in_last[g]` when an input transfer occurs.
  - `out_valid` is set on load.
  - `out_valid` is cleared on an output transfer with no simultaneous load.
  - A simultaneous output transfer and load keeps `out_valid` = 1 and replaces the data.
  - Data holds while `out_valid && !out_ready`.
- **Owner bubbles:** if the owner deasserts `in_valid` mid-packet, the grant is held. Other requesters stay blocked until the owner's last flit transfers.
- **Single-flit packets:** `in_last` = 1 on the first flit completes the packet in one transfer.
- **Mid-packet requests:** `in_valid` from non-owners is ignored; no state is kept for them.
- **Reset values** (immediate on `rst` low, regardless of clock):
  - `out_valid` = 0, `out_flit` = 0, `out_last` = 0.
  - `in_ready` = 0, `grant` = 0, `busy` = 0.
  - `ptr` = 0, state IDLE.
  - A packet in flight at reset is dropped; no partial state survives.

## Timing

- **Arbitration latency:** a request seen in IDLE at edge N gives `grant`/`busy` after edge N. The first flit can transfer at edge N+1 and appears on `out_valid` after edge N+1.
- **Throughput:** 1 flit/cycle within a packet when `out_ready` = 1.
- **Inter-packet gap:** a last flit transferred at edge M leaves the block IDLE for cycle M..M+1. The next packet's first flit transfers no earlier than edge M+2, i.e. one bubble cycle per packet.
- **Backpressure path:** `in_ready` depends combinationally on `out_ready` and registered state only. It never depends on `in_valid` (no combinational valid→ready loop).
- **Registered outputs:** `out_*`, `grant` and `busy` are registered.

## Test plan

- **Single 3-flit packet:** after reset, input 0 presents A0, A1, A2 (last on A2), `out_ready` = 1.
  - `grant` = 0001 after edge 1.
  - `out_flit` = A0, A1, A2 on consecutive cycles from edge 2.
  - `out_last` = 1 only with A2.
  - `busy` = 0 after the A2 transfer.
- **Contention:** all 4 inputs request 2-flit packets simultaneously from reset.
  - Grant order 0, 1, 2, 3, each packet contiguous on `out`.
  - Exactly one idle cycle between packets; `ptr` returns to 0 afterwards.
- **Round-robin wrap:** with `ptr` = 3 and only inputs 0 and 2 requesting, input 0 is granted; after its last flit, input 2 is granted.
- **Backpressure:** `out_ready` = 0 for 3 cycles mid-packet.
  - `out_flit`/`out_last` held stable and `in_ready[g]` = 0 during the stall.
  - No flit lost or duplicated; the sequence out matches the sequence in.
- **Owner bubble:** the owner drops `in_valid` for 2 cycles mid-packet while input 1 is valid. `grant` is unchanged and `in_ready[1]` = 0 until the owner's last flit transfers.
- **Reset mid-packet:** assert `rst` low asynchronously between edges during flit 2 of 4.
  - All outputs read 0 before the next edge.
  - After release, input 0 wins against simultaneous input 2.
  - No remnant flits appear on `out`.

Source files
------------

// File: rtl/peripheral_noc_router_packet_arbiter_if.sv
// ---------------------------------------------------------------------------
// peripheral_noc_router_packet_arbiter_if
//
// Bundles the requester-side and output-side handshake signals of the
// packet arbiter.
//
//   in_flit   : flit from each requester (packed [INPUTS-1:0][FLIT_WIDTH-1:0])
//   in_last   : final flit of packet, per requester
//   in_valid  : requester has a flit
//   in_ready  : flit accepted this cycle (at most one bit set)
//   out_flit  : registered flit towards the output stage
//   out_last  : registered last marker
//   out_valid : out_flit/out_last valid
//   out_ready : downstream accepts
//   grant     : one-hot current owner, zero when idle
//   busy      : arbiter locked to a packet
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding switch/output-buffer logic driving it
// ---------------------------------------------------------------------------
interface peripheral_noc_router_packet_arbiter_if #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned INPUTS     = 4
);

  logic [INPUTS-1:0][FLIT_WIDTH-1:0] in_flit;
  logic [INPUTS-1:0]                 in_last;
  logic [INPUTS-1:0]                 in_valid;
  logic [INPUTS-1:0]                 in_ready;
  logic [FLIT_WIDTH-1:0]             out_flit;
  logic                              out_last;
  logic                              out_valid;
  logic                              out_ready;
  logic [INPUTS-1:0]                 grant;
  logic                              busy;

  modport slave (
    input  in_flit,
    input  in_last,
    input  in_valid,
    output in_ready,
    output out_flit,
    output out_last,
    output out_valid,
    input  out_ready,
    output grant,
    output busy
  );

  modport master (
    output in_flit,
    output in_last,
    output in_valid,
    input  in_ready,
    input  out_flit,
    input  out_last,
    input  out_valid,
    output out_ready,
    input  grant,
    input  busy
  );

endinterface

// File: rtl/peripheral_noc_router_packet_arbiter.sv
// ---------------------------------------------------------------------------
// peripheral_noc_router_packet_arbiter
//
// Packet-atomic round-robin arbiter sharing one router output link (or one
// output VC) between INPUTS requesters. Once an input is granted it keeps the
// link until its last flit transfers, so packets never interleave. The
// selected flit stream passes through a single registered output stage.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : handshake bundle (slave modport), see the interface file
//
// Parameters:
//   FLIT_WIDTH : flit width in bits
//   INPUTS     : number of requesters (>= 2)
// ---------------------------------------------------------------------------
module peripheral_noc_router_packet_arbiter #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned INPUTS     = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  peripheral_noc_router_packet_arbiter_if.slave    bus
);

  localparam int unsigned      PTR_W    = $clog2(INPUTS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(INPUTS - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                  state_q;
  logic [PTR_W-1:0]        ptr_q;
  logic [PTR_W-1:0]        grant_idx_q;
  logic [INPUTS-1:0]       grant_q;
  logic                    busy_q;
  logic [FLIT_WIDTH-1:0]   out_flit_q;
  logic                    out_last_q;
  logic                    out_valid_q;

  logic                    pick_valid;
  logic [PTR_W-1:0]        pick_idx;
  logic [INPUTS-1:0]       grant_d;
  logic [PTR_W-1:0]        ptr_d;
  logic                    out_free;
  logic [INPUTS-1:0]       in_ready;
  logic                    in_xfer;
  logic [FLIT_WIDTH-1:0]   sel_flit;
  logic                    sel_last;

  // Round-robin search: first valid requester at or above ptr_q, wrapping.
  always_comb begin
    int unsigned      cand;
    logic [PTR_W-1:0] cand_idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < INPUTS; k++) begin
      cand     = (32'(ptr_q) + k) % INPUTS;
      cand_idx = PTR_W'(cand);
      if (!pick_valid && bus.in_valid[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign grant_d = {{(INPUTS-1){1'b0}}, 1'b1} << pick_idx;

  // Pointer moves past the owner only when its packet completes.
  assign ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;

  // Ready is a function of registered state and out_ready only; the owner's
  // in_valid never feeds back into in_ready.
  assign out_free = !out_valid_q || bus.out_ready;
  assign in_ready = busy_q ? (grant_q & {INPUTS{out_free}}) : '0;
  assign in_xfer  = |(in_ready & bus.in_valid);

  // One-hot grant mux for the owner's flit and last marker.
  always_comb begin
    sel_flit = '0;
    for (int unsigned k = 0; k < INPUTS; k++) begin
      if (grant_q[k]) begin
        sel_flit = sel_flit | bus.in_flit[k];
      end
    end
  end

  assign sel_last = |(grant_q & bus.in_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      out_flit_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q     <= LOCKED;
            busy_q      <= 1'b1;
            grant_q     <= grant_d;
            grant_idx_q <= pick_idx;
          end
        end
        LOCKED: begin
          if (in_xfer && sel_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            grant_q <= '0;
            ptr_q   <= ptr_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          grant_q <= '0;
        end
      endcase

      // Output stage: a load wins over a drain, so a simultaneous in/out
      // transfer keeps out_valid high with the new flit.
      if (in_xfer) begin
        out_flit_q  <= sel_flit;
        out_last_q  <= sel_last;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_flit  = out_flit_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;

endmodule
